// File: rtl/match_select_ctrl_pkg.sv
// Shared types for the deflate best-match scheduler: default widths, bank count,
// per-slot record and output FSM encoding.
package match_select_ctrl_pkg;

    localparam int unsigned NUM_BANKS = 3;
    localparam int unsigned DEF_LEN_W = 5;
    localparam int unsigned DEF_POS_W = 32;

    // Index 0 is bank b1, index 2 is bank b3.
    typedef struct packed {
        logic                                  busy;
        logic [NUM_BANKS-1:0]                  got;
        logic [NUM_BANKS-1:0]                  hit;
        logic [NUM_BANKS-1:0][DEF_LEN_W-1:0]   len;
        logic [NUM_BANKS-1:0][DEF_POS_W-1:0]   pos;
        logic [DEF_POS_W-1:0]                  cur_pos;
    } slot_t;

    typedef enum logic {
        StIdle,
        StHold
    } out_state_e;

endpackage

// File: rtl/match_best_sel.sv
// Combinational pick of the longest hit among the three banks; on equal length the
// lower bank index wins. No hit yields zero length and position.
module match_best_sel
    import match_select_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned POS_W = DEF_POS_W
) (
    input  logic [NUM_BANKS-1:0]            hit_i,
    input  logic [NUM_BANKS-1:0][LEN_W-1:0] len_i,
    input  logic [NUM_BANKS-1:0][POS_W-1:0] pos_i,
    output logic                            hit_o,
    output logic [LEN_W-1:0]                len_o,
    output logic [POS_W-1:0]                pos_o
);

    always_comb begin
        hit_o = 1'b0;
        len_o = '0;
        pos_o = '0;
        // Strict compare keeps the earlier (higher priority) bank on ties.
        for (int n = 0; n < NUM_BANKS; n++) begin
            if (hit_i[n] && (!hit_o || (len_i[n] > len_o))) begin
                hit_o = 1'b1;
                len_o = len_i[n];
                pos_o = pos_i[n];
            end
        end
    end

endmodule

// File: rtl/match_select_ctrl.sv
// Best-match scheduler: tagged slot ring collecting out-of-order bank returns, in-order
// retirement over valid/ready, and a head timeout that forces stalled slots out.
module match_select_ctrl
    import match_select_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned POS_W     = DEF_POS_W,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [POS_W-1:0]             issue_pos,
    output logic [$clog2(NUM_SLOTS)-1:0] issue_tag,
    input  logic                         b1_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] b1_tag,
    input  logic                         b1_hit,
    input  logic [LEN_W-1:0]             b1_len,
    input  logic [POS_W-1:0]             b1_pos,
    input  logic                         b2_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] b2_tag,
    input  logic                         b2_hit,
    input  logic [LEN_W-1:0]             b2_len,
    input  logic [POS_W-1:0]             b2_pos,
    input  logic                         b3_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] b3_tag,
    input  logic                         b3_hit,
    input  logic [LEN_W-1:0]             b3_len,
    input  logic [POS_W-1:0]             b3_pos,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_hit,
    output logic [LEN_W-1:0]             out_len,
    output logic [POS_W-1:0]             out_pos,
    output logic [POS_W-1:0]             out_cur_pos,
    output logic                         err_proto,
    output logic                         err_timeout
);

    localparam int unsigned TAG_W = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);
    localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT);

    slot_t                          slots_q [NUM_SLOTS];
    slot_t                          slots_d [NUM_SLOTS];
    logic [TAG_W-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [TMR_W-1:0]               timer_q, timer_d;
    out_state_e                     state_q, state_d;
    logic                           out_hit_q, out_hit_d;
    logic [LEN_W-1:0]               out_len_q, out_len_d;
    logic [POS_W-1:0]               out_pos_q, out_pos_d;
    logic [POS_W-1:0]               out_cur_pos_q, out_cur_pos_d;
    logic                           err_proto_q, err_proto_d;
    logic                           err_timeout_q, err_timeout_d;

    logic [NUM_BANKS-1:0]             ret_valid, ret_hit;
    logic [NUM_BANKS-1:0][TAG_W-1:0]  ret_tag;
    logic [NUM_BANKS-1:0][LEN_W-1:0]  ret_len;
    logic [NUM_BANKS-1:0][POS_W-1:0]  ret_pos;

    slot_t            head_slot;
    logic             all_got, timed_out, head_complete, load, issue_fire;
    logic             sel_hit;
    logic [LEN_W-1:0] sel_len;
    logic [POS_W-1:0] sel_pos;

    assign ret_valid = {b3_valid, b2_valid, b1_valid};
    assign ret_hit   = {b3_hit, b2_hit, b1_hit};
    assign ret_tag   = {b3_tag, b2_tag, b1_tag};
    assign ret_len   = {b3_len, b2_len, b1_len};
    assign ret_pos   = {b3_pos, b2_pos, b1_pos};

    assign issue_ready   = (count_q != FULL_CNT);
    assign issue_tag     = tail_q;
    assign issue_fire    = issue_valid && issue_ready;
    assign head_slot     = slots_q[head_q];
    assign all_got       = &head_slot.got;
    assign timed_out     = head_slot.busy && !all_got && (timer_q == TIMER_MAX);
    assign head_complete = head_slot.busy && (all_got || timed_out);
    assign load          = head_complete && ((state_q == StIdle) || out_ready);

    // Banks that never returned are masked out so a timed-out slot sees them as misses.
    match_best_sel #(
        .LEN_W (LEN_W),
        .POS_W (POS_W)
    ) u_best_sel (
        .hit_i (head_slot.hit & head_slot.got),
        .len_i (head_slot.len),
        .pos_i (head_slot.pos),
        .hit_o (sel_hit),
        .len_o (sel_len),
        .pos_o (sel_pos)
    );

    always_comb begin
        slots_d     = slots_q;
        err_proto_d = err_proto_q;
        for (int n = 0; n < NUM_BANKS; n++) begin
            if (ret_valid[n]) begin
                if (!slots_q[ret_tag[n]].busy || slots_q[ret_tag[n]].got[n]) begin
                    err_proto_d = 1'b1;
                end else begin
                    slots_d[ret_tag[n]].got[n] = 1'b1;
                    slots_d[ret_tag[n]].hit[n] = ret_hit[n];
                    slots_d[ret_tag[n]].len[n] = ret_len[n];
                    slots_d[ret_tag[n]].pos[n] = ret_pos[n];
                end
            end
        end
        if (load) begin
            slots_d[head_q].busy = 1'b0;
        end
        // Tail never equals a retiring head here: issue is blocked whenever the ring is full.
        if (issue_fire) begin
            slots_d[tail_q]         = '0;
            slots_d[tail_q].busy    = 1'b1;
            slots_d[tail_q].cur_pos = issue_pos;
        end
    end

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        timer_d       = timer_q;
        state_d       = state_q;
        out_hit_d     = out_hit_q;
        out_len_d     = out_len_q;
        out_pos_d     = out_pos_q;
        out_cur_pos_d = out_cur_pos_q;
        err_timeout_d = err_timeout_q;

        if (issue_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (load) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(issue_fire) - CNT_W'(load);

        if (load || !head_slot.busy) begin
            timer_d = '0;
        end else if (!all_got && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + 1'b1;
        end

        if (load) begin
            out_hit_d     = sel_hit;
            out_len_d     = sel_len;
            out_pos_d     = sel_pos;
            out_cur_pos_d = head_slot.cur_pos;
            if (timed_out) begin
                err_timeout_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: if (load) state_d = StHold;
            StHold: begin
                if (load) begin
                    state_d = StHold;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            state_q       <= StIdle;
            out_hit_q     <= 1'b0;
            out_len_q     <= '0;
            out_pos_q     <= '0;
            out_cur_pos_q <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            state_q       <= state_d;
            out_hit_q     <= out_hit_d;
            out_len_q     <= out_len_d;
            out_pos_q     <= out_pos_d;
            out_cur_pos_q <= out_cur_pos_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign out_valid   = (state_q == StHold);
    assign out_hit     = out_hit_q;
    assign out_len     = out_len_q;
    assign out_pos     = out_pos_q;
    assign out_cur_pos = out_cur_pos_q;
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_match_select_ctrl.sv
// Directed self-checking bench for match_select_ctrl with hand-computed expectations.
module tb_match_select_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_pos;
    logic [1:0]  issue_tag;
    logic        b1_valid, b1_hit, b2_valid, b2_hit, b3_valid, b3_hit;
    logic [1:0]  b1_tag, b2_tag, b3_tag;
    logic [4:0]  b1_len, b2_len, b3_len;
    logic [31:0] b1_pos, b2_pos, b3_pos;
    logic        out_valid, out_ready, out_hit;
    logic [4:0]  out_len;
    logic [31:0] out_pos, out_cur_pos;
    logic        err_proto, err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_select_ctrl #(
        .NUM_SLOTS (4),
        .LEN_W     (5),
        .POS_W     (32),
        .TIMEOUT   (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_pos   (issue_pos),
        .issue_tag   (issue_tag),
        .b1_valid    (b1_valid),
        .b1_tag      (b1_tag),
        .b1_hit      (b1_hit),
        .b1_len      (b1_len),
        .b1_pos      (b1_pos),
        .b2_valid    (b2_valid),
        .b2_tag      (b2_tag),
        .b2_hit      (b2_hit),
        .b2_len      (b2_len),
        .b2_pos      (b2_pos),
        .b3_valid    (b3_valid),
        .b3_tag      (b3_tag),
        .b3_hit      (b3_hit),
        .b3_len      (b3_len),
        .b3_pos      (b3_pos),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hit     (out_hit),
        .out_len     (out_len),
        .out_pos     (out_pos),
        .out_cur_pos (out_cur_pos),
        .err_proto   (err_proto),
        .err_timeout (err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_banks();
        b1_valid = 0; b2_valid = 0; b3_valid = 0;
    endtask

    task automatic set_bank(input int b, input logic [1:0] tag, input logic h,
                            input logic [4:0] l, input logic [31:0] p);
        case (b)
            1: begin b1_valid = 1; b1_tag = tag; b1_hit = h; b1_len = l; b1_pos = p; end
            2: begin b2_valid = 1; b2_tag = tag; b2_hit = h; b2_len = l; b2_pos = p; end
            default: begin b3_valid = 1; b3_tag = tag; b3_hit = h; b3_len = l; b3_pos = p; end
        endcase
    endtask

    task automatic ret1(input int b, input logic [1:0] tag, input logic h,
                        input logic [4:0] l, input logic [31:0] p);
        set_bank(b, tag, h, l, p);
        tick();
        clear_banks();
    endtask

    task automatic issue(input logic [31:0] p);
        issue_valid = 1;
        issue_pos   = p;
        tick();
        issue_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        issue_valid = 0;
        out_ready = 0;
        clear_banks();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 0 || issue_ready !== 1 || issue_tag !== 0) begin
            errors++;
            $display("FAIL reset_ctl: valid=%0b ready=%0b tag=%0d want 0 1 0",
                     out_valid, issue_ready, issue_tag);
        end
        checks++;
        if (out_hit !== 0 || out_len !== 0 || out_pos !== 0 || out_cur_pos !== 0 ||
            err_proto !== 0 || err_timeout !== 0) begin
            errors++;
            $display("FAIL reset_out: hit=%0b len=%0d pos=%0d cur=%0d ep=%0b et=%0b want all 0",
                     out_hit, out_len, out_pos, out_cur_pos, err_proto, err_timeout);
        end
    endtask

    task automatic test_tie_latency();
        do_reset();
        out_ready = 1;
        issue(100);
        ret1(3, 0, 1, 7, 40);
        ret1(1, 0, 1, 7, 60);
        ret1(2, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL lat_early: out_valid=%0b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1 || out_hit !== 1 || out_len !== 7 || out_pos !== 60 ||
            out_cur_pos !== 100) begin
            errors++;
            $display("FAIL tie_result: v=%0b hit=%0b len=%0d pos=%0d cur=%0d want 1 1 7 60 100",
                     out_valid, out_hit, out_len, out_pos, out_cur_pos);
        end
        tick();
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL tie_drain: out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_out_of_order();
        int order [4] = '{3, 1, 0, 2};
        int k = 0;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (issue_tag !== 2'(i)) begin
                errors++;
                $display("FAIL ooo_tag: tag=%0d want %0d", issue_tag, i);
            end
            issue(200 + i);
        end
        checks++;
        if (issue_ready !== 0) begin
            errors++;
            $display("FAIL ooo_full: issue_ready=%0b want 0", issue_ready);
        end
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                set_bank(1, 2'(order[c]), 1, 5'(order[c] + 1), 1000 + order[c]);
                set_bank(2, 2'(order[c]), 1, 5'(order[c] + 10), 2000 + order[c]);
                set_bank(3, 2'(order[c]), 0, 31, 3000);
            end
            tick();
            clear_banks();
            if (out_valid && k < 4) begin
                checks++;
                if (out_cur_pos !== 200 + k || out_len !== 5'(k + 10) || out_pos !== 2000 + k) begin
                    errors++;
                    $display("FAIL ooo_result%0d: cur=%0d len=%0d pos=%0d want %0d %0d %0d",
                             k, out_cur_pos, out_len, out_pos, 200 + k, k + 10, 2000 + k);
                end
                if (k == 0) begin
                    checks++;
                    if (issue_ready !== 1) begin
                        errors++;
                        $display("FAIL ooo_ready_back: issue_ready=%0b want 1", issue_ready);
                    end
                end
                k++;
            end
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL ooo_count: results=%0d want 4", k);
        end
    endtask

    task automatic test_backpressure();
        logic stable = 1;
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 3; i++) issue(300 + i);
        for (int t = 0; t < 3; t++) begin
            set_bank(1, 2'(t), 1, 5'(5 + t), 10 + t);
            set_bank(2, 2'(t), 0, 0, 0);
            set_bank(3, 2'(t), 0, 0, 0);
            tick();
            clear_banks();
        end
        tick();
        checks++;
        if (out_valid !== 1 || out_cur_pos !== 300 || out_len !== 5 || out_pos !== 10) begin
            errors++;
            $display("FAIL bp_first: v=%0b cur=%0d len=%0d pos=%0d want 1 300 5 10",
                     out_valid, out_cur_pos, out_len, out_pos);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1 || out_cur_pos !== 300 || out_len !== 5 || out_pos !== 10)
                stable = 0;
        end
        checks++;
        if (stable !== 1) begin
            errors++;
            $display("FAIL bp_stable: last v=%0b cur=%0d want held 1 300", out_valid, out_cur_pos);
        end
        out_ready = 1;
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1 || out_cur_pos !== 300 + i || out_len !== 5'(5 + i)) begin
                errors++;
                $display("FAIL bp_burst%0d: v=%0b cur=%0d len=%0d want 1 %0d %0d",
                         i, out_valid, out_cur_pos, out_len, 300 + i, 5 + i);
            end
        end
        tick();
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL bp_end: out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_timeout();
        int n = 2;
        do_reset();
        out_ready = 1;
        issue(400);
        ret1(1, 0, 1, 3, 11);
        ret1(2, 0, 1, 9, 22);
        while (n < 40) begin
            tick();
            n++;
            if (out_valid) break;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL to_cycles: retired after %0d edges want 16", n);
        end
        checks++;
        if (out_valid !== 1 || out_hit !== 1 || out_len !== 9 || out_pos !== 22 ||
            out_cur_pos !== 400 || err_timeout !== 1 || err_proto !== 0) begin
            errors++;
            $display("FAIL to_result: v=%0b h=%0b len=%0d pos=%0d cur=%0d et=%0b ep=%0b want 1 1 9 22 400 1 0",
                     out_valid, out_hit, out_len, out_pos, out_cur_pos, err_timeout, err_proto);
        end
        issue(401);
        rst_n = 0;
        #1;
        checks++;
        if (err_timeout !== 0 || issue_ready !== 1 || out_valid !== 0 || issue_tag !== 0) begin
            errors++;
            $display("FAIL to_reset: et=%0b ready=%0b v=%0b tag=%0d want 0 1 0 0",
                     err_timeout, issue_ready, out_valid, issue_tag);
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_proto();
        do_reset();
        ret1(1, 2, 1, 4, 4);
        checks++;
        if (err_proto !== 1 || out_valid !== 0) begin
            errors++;
            $display("FAIL proto_free: ep=%0b v=%0b want 1 0", err_proto, out_valid);
        end
        do_reset();
        out_ready = 1;
        issue(500);
        ret1(1, 0, 1, 4, 44);
        checks++;
        if (err_proto !== 0) begin
            errors++;
            $display("FAIL proto_clean: ep=%0b want 0", err_proto);
        end
        ret1(1, 0, 1, 20, 99);
        checks++;
        if (err_proto !== 1) begin
            errors++;
            $display("FAIL proto_dup: ep=%0b want 1", err_proto);
        end
        ret1(2, 0, 0, 0, 0);
        ret1(3, 0, 1, 2, 55);
        tick();
        checks++;
        if (out_valid !== 1 || out_len !== 4 || out_pos !== 44 || out_cur_pos !== 500) begin
            errors++;
            $display("FAIL proto_data: v=%0b len=%0d pos=%0d cur=%0d want 1 4 44 500",
                     out_valid, out_len, out_pos, out_cur_pos);
        end
    endtask

    task automatic test_all_miss_same_cycle();
        do_reset();
        out_ready = 1;
        issue(600);
        issue(601);
        set_bank(1, 0, 0, 5, 77);
        set_bank(2, 0, 0, 5, 77);
        set_bank(3, 0, 0, 5, 77);
        tick();
        clear_banks();
        tick();
        checks++;
        if (out_valid !== 1 || out_hit !== 0 || out_len !== 0 || out_pos !== 0 ||
            out_cur_pos !== 600 || err_proto !== 0) begin
            errors++;
            $display("FAIL miss_result: v=%0b h=%0b len=%0d pos=%0d cur=%0d ep=%0b want 1 0 0 0 600 0",
                     out_valid, out_hit, out_len, out_pos, out_cur_pos, err_proto);
        end
        set_bank(1, 1, 1, 11, 3);
        set_bank(2, 1, 1, 12, 1);
        set_bank(3, 1, 1, 12, 2);
        tick();
        clear_banks();
        tick();
        checks++;
        if (out_valid !== 1 || out_hit !== 1 || out_len !== 12 || out_pos !== 1 ||
            out_cur_pos !== 601) begin
            errors++;
            $display("FAIL tie23_result: v=%0b h=%0b len=%0d pos=%0d cur=%0d want 1 1 12 1 601",
                     out_valid, out_hit, out_len, out_pos, out_cur_pos);
        end
    endtask

    initial begin
        issue_valid = 0;
        issue_pos   = 0;
        out_ready   = 0;
        b1_tag = 0; b1_hit = 0; b1_len = 0; b1_pos = 0;
        b2_tag = 0; b2_hit = 0; b2_len = 0; b2_pos = 0;
        b3_tag = 0; b3_hit = 0; b3_len = 0; b3_pos = 0;
        clear_banks();
        test_reset();
        test_tie_latency();
        test_out_of_order();
        test_backpressure();
        test_timeout();
        test_proto();
        test_all_miss_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
